// File: rtl/cc_mem_read_responder.sv
// Memory-side AXI read responder: queues AR requests, waits LATENCY cycles, then streams
// INCR/WRAP/FIXED bursts from a backdoor-loaded word array. Optional macro: CC_MEM_RESP_STALL_EN.
module cc_mem_read_responder #(
    parameter int ADDR_DEPTH_LOG2 = 10,
    parameter int AR_FIFO_DEPTH   = 4,
    parameter int LATENCY         = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_arvalid_i,
    output logic                       mem_arready_o,
    input  logic [31:0]                mem_araddr_i,
    input  logic [3:0]                 mem_arlen_i,
    input  logic [1:0]                 mem_arburst_i,
    output logic [63:0]                mem_rdata_o,
    output logic                       mem_rlast_o,
    output logic                       mem_rvalid_o,
    input  logic                       mem_rready_i,
    input  logic                       init_wren_i,
    input  logic [ADDR_DEPTH_LOG2-1:0] init_addr_i,
    input  logic [63:0]                init_wdata_i
);
    localparam int AW    = ADDR_DEPTH_LOG2;
    localparam int PW    = $clog2(AR_FIFO_DEPTH);
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [3:0]    len;
        logic [1:0]    burst;
    } ar_req_t;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

    // AR request queue
    ar_req_t     fifo_q [AR_FIFO_DEPTH];
    logic [PW:0] wr_ptr_q, rd_ptr_q;
    logic        full, empty, push, pop;
    ar_req_t     push_req, head;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_araddr_i[31:AW+3], mem_araddr_i[2:0]};

    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = mem_arvalid_i && !full;
    assign mem_arready_o = !full;

    assign push_req.idx   = mem_araddr_i[AW+2:3];
    assign push_req.len   = mem_arlen_i;
    assign push_req.burst = mem_arburst_i;
    assign head = fifo_q[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q[PW-1:0]] <= push_req;
    end

    // Word array; not reset, loaded through the backdoor port
    logic [63:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (init_wren_i) mem_q[init_addr_i] <= init_wdata_i;
    end

    function automatic logic [AW-1:0] next_index(input logic [AW-1:0] idx,
                                                 input logic [3:0]    len,
                                                 input logic [1:0]    burst);
        logic [AW-1:0] mask;
        logic [AW-1:0] inc;
        logic          wrap_ok;
        mask    = AW'(len);
        inc     = idx + AW'(1);
        // WRAP only for power-of-two burst lengths; anything else falls back to INCR
        wrap_ok = (len != 4'd0) && ((len & (len + 4'd1)) == 4'd0);
        case (burst)
            2'b00:   next_index = idx;
            2'b10:   next_index = wrap_ok ? ((idx & ~mask) | (inc & mask)) : inc;
            default: next_index = inc;
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [3:0]    len_q, len_d;
    logic [1:0]    burst_q, burst_d;
    logic [3:0]    beat_q, beat_d;
    logic          rvalid_q, rvalid_d;
    logic          rlast_q, rlast_d;
    logic [63:0]   rdata_q;
    logic          load_beat;
    logic [AW-1:0] rd_idx, nxt_idx;
`ifdef CC_MEM_RESP_STALL_EN
    logic          stall_q, stall_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        len_d     = len_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        pop       = 1'b0;
        load_beat = 1'b0;
        rd_idx    = idx_q;
        nxt_idx   = next_index(idx_q, len_q, burst_q);
`ifdef CC_MEM_RESP_STALL_EN
        stall_d   = stall_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    idx_d   = head.idx;
                    len_d   = head.len;
                    burst_d = head.burst;
                    beat_d  = 4'd0;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    load_beat = 1'b1;
                    rd_idx    = idx_q;
                    rvalid_d  = 1'b1;
                    rlast_d   = (len_q == 4'd0);
                    state_d   = S_BURST;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_BURST: begin
`ifdef CC_MEM_RESP_STALL_EN
                if (stall_q) begin
                    // bubble cycle is over: launch the beat whose address was advanced last edge
                    load_beat = 1'b1;
                    rd_idx    = idx_q;
                    rvalid_d  = 1'b1;
                    rlast_d   = (beat_q == len_q);
                    stall_d   = 1'b0;
                end else
`endif
                if (rvalid_q && mem_rready_i) begin
                    if (rlast_q) begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        idx_d  = nxt_idx;
                        beat_d = beat_q + 4'd1;
`ifdef CC_MEM_RESP_STALL_EN
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        stall_d  = 1'b1;
`else
                        load_beat = 1'b1;
                        rd_idx    = nxt_idx;
                        rvalid_d  = 1'b1;
                        rlast_d   = ((beat_q + 4'd1) == len_q);
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            len_q    <= '0;
            burst_q  <= '0;
            beat_q   <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
`ifdef CC_MEM_RESP_STALL_EN
            stall_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            burst_q  <= burst_d;
            beat_q   <= beat_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
`ifdef CC_MEM_RESP_STALL_EN
            stall_q  <= stall_d;
`endif
        end
    end

    // Synchronous read; a same-edge backdoor write lands after the read, giving old data
    always_ff @(posedge clk) begin
        if (rst)            rdata_q <= '0;
        else if (load_beat) rdata_q <= mem_q[rd_idx];
    end

    assign mem_rdata_o  = rdata_q;
    assign mem_rlast_o  = rlast_q;
    assign mem_rvalid_o = rvalid_q;

endmodule

// File: tb/tb_cc_mem_read_responder.sv
// Directed bench for cc_mem_read_responder: vector table of bursts plus hand sequences
// for backpressure, queue-full, read-before-write and mid-burst reset.
module tb_cc_mem_read_responder;
    localparam int AW  = 10;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [31:0]   araddr = '0;
    logic [3:0]    arlen = '0;
    logic [1:0]    arburst = '0;
    logic [63:0]   rdata;
    logic          rlast;
    logic          rvalid;
    logic          rready = 1'b1;
    logic          init_wren = 1'b0;
    logic [AW-1:0] init_addr = '0;
    logic [63:0]   init_wdata = '0;

    int total = 0;
    int bad   = 0;

    cc_mem_read_responder #(.ADDR_DEPTH_LOG2(AW), .AR_FIFO_DEPTH(4), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .mem_arvalid_i(arvalid), .mem_arready_o(arready), .mem_araddr_i(araddr),
        .mem_arlen_i(arlen), .mem_arburst_i(arburst),
        .mem_rdata_o(rdata), .mem_rlast_o(rlast), .mem_rvalid_o(rvalid), .mem_rready_i(rready),
        .init_wren_i(init_wren), .init_addr_i(init_addr), .init_wdata_i(init_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  len;
        logic [1:0]  burst;
        int          exp_idx [16];
    } vec_t;

    vec_t vecs [8];

    function automatic logic [63:0] word(input int i);
        return 64'hA000_0000_0000_0000 + 64'(i);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_burst(input vec_t v, input string nm);
        int n;
        check({nm, " arready"}, 64'(arready), 64'd1);
        arvalid = 1'b1; araddr = v.addr; arlen = v.len; arburst = v.burst;
        step();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 40) begin
            step();
            n++;
        end
        check({nm, " latency"}, 64'(n), 64'(LAT + 1));
        for (int b = 0; b <= int'(v.len); b++) begin
`ifdef CC_MEM_RESP_STALL_EN
            if (b > 0) begin
                check($sformatf("%s gap%0d", nm, b), 64'(rvalid), 64'd0);
                step();
            end
`endif
            check($sformatf("%s rvalid%0d", nm, b), 64'(rvalid), 64'd1);
            check($sformatf("%s data%0d", nm, b), rdata, word(v.exp_idx[b]));
            check($sformatf("%s rlast%0d", nm, b), 64'(rlast), 64'(b == int'(v.len)));
            step();
        end
        check({nm, " idle after"}, 64'(rvalid), 64'd0);
    endtask

    initial begin
        int n, seen, beat, cyc, last_cyc, nxt_cyc, hi;

        vecs[0].addr = 32'h40;        vecs[0].len = 4'd7; vecs[0].burst = 2'b01;
        vecs[0].exp_idx = '{8, 9, 10, 11, 12, 13, 14, 15, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1].addr = 32'h58;        vecs[1].len = 4'd7; vecs[1].burst = 2'b10;
        vecs[1].exp_idx = '{11, 12, 13, 14, 15, 8, 9, 10, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2].addr = 32'h10;        vecs[2].len = 4'd3; vecs[2].burst = 2'b00;
        vecs[2].exp_idx = '{2, 2, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[3].addr = 32'h8000_1FF8; vecs[3].len = 4'd1; vecs[3].burst = 2'b01;
        vecs[3].exp_idx = '{1023, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[4].addr = 32'h30;        vecs[4].len = 4'd3; vecs[4].burst = 2'b10;
        vecs[4].exp_idx = '{6, 7, 4, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[5].addr = 32'hA0;        vecs[5].len = 4'd2; vecs[5].burst = 2'b11;
        vecs[5].exp_idx = '{20, 21, 22, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[6].addr = 32'h38;        vecs[6].len = 4'd2; vecs[6].burst = 2'b10;
        vecs[6].exp_idx = '{7, 8, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[7].addr = 32'h2F;        vecs[7].len = 4'd0; vecs[7].burst = 2'b01;
        vecs[7].exp_idx = '{5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        rst = 1'b1;
        step(); step(); step();
        rst = 1'b0;
        step();
        check("reset arready", 64'(arready), 64'd1);
        check("reset rvalid", 64'(rvalid), 64'd0);
        check("reset rlast", 64'(rlast), 64'd0);
        check("reset rdata", rdata, 64'd0);

        for (int i = 0; i < (1 << AW); i++) begin
            init_wren = 1'b1; init_addr = AW'(i); init_wdata = word(i);
            step();
        end
        init_wren = 1'b0;

        rready = 1'b1;
        for (int i = 0; i < 8; i++) do_burst(vecs[i], $sformatf("vec%0d", i));

        // read-before-write: backdoor write on the launch edge of a single-beat read
        arvalid = 1'b1; araddr = 32'h28; arlen = 4'd0; arburst = 2'b01;
        step();
        arvalid = 1'b0;
        step();
        step();
        init_wren = 1'b1; init_addr = AW'(5); init_wdata = 64'h5555_6666_7777_8888;
        step();
        init_wren = 1'b0;
        check("rbw rvalid", 64'(rvalid), 64'd1);
        check("rbw old data", rdata, word(5));
        step();
        check("rbw done", 64'(rvalid), 64'd0);
        arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 40) begin step(); n++; end
        check("rbw new data", rdata, 64'h5555_6666_7777_8888);
        init_wren = 1'b1; init_addr = AW'(5); init_wdata = word(5);
        step();
        init_wren = 1'b0;

        // backpressure: fill the queue while rready is low
        rready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp arready%0d", k), 64'(arready), 64'd1);
            arvalid = 1'b1; araddr = 32'((32 + 8 * k) * 8); arlen = 4'd7; arburst = 2'b01;
            step();
        end
        arvalid = 1'b0;
        check("bp full", 64'(arready), 64'd0);
        n = 0;
        while (!rvalid && n < 40) begin step(); n++; end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp hold rvalid%0d", k), 64'(rvalid), 64'd1);
            check($sformatf("bp hold data%0d", k), rdata, word(32));
            check($sformatf("bp hold rlast%0d", k), 64'(rlast), 64'd0);
            step();
        end
        rready = 1'b1;
        beat = 0; cyc = 0; last_cyc = -10; nxt_cyc = -10;
        while (beat < 40 && cyc < 400) begin
            if (cyc == last_cyc + 1) check("bp arready before pop", 64'(arready), 64'd0);
            if (cyc == last_cyc + 2) check("bp arready after pop", 64'(arready), 64'd1);
            if (rvalid) begin
                check($sformatf("bp data%0d", beat), rdata, word(32 + beat));
                check($sformatf("bp rlast%0d", beat), 64'(rlast), 64'((beat % 8) == 7));
                if (beat == 7) last_cyc = cyc;
                if (beat == 8) nxt_cyc = cyc;
                beat++;
            end
            step();
            cyc++;
        end
        check("bp beats", 64'(beat), 64'd40);
        check("bp burst gap", 64'(nxt_cyc - last_cyc), 64'd4);

        // reset during beat 4 with two requests still queued
        for (int k = 0; k < 3; k++) begin
            arvalid = 1'b1; araddr = 32'((256 + 8 * k) * 8); arlen = 4'd7; arburst = 2'b01;
            step();
        end
        arvalid = 1'b0;
        n = 0; seen = 0;
        while (n < 40) begin
            if (rvalid) begin
                check($sformatf("rst pre data%0d", seen), rdata, word(256 + seen));
                if (seen == 3) break;
                seen++;
            end
            step();
            n++;
        end
        check("rst beat4 reached", 64'(seen), 64'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst rvalid", 64'(rvalid), 64'd0);
        check("rst arready", 64'(arready), 64'd1);
        check("rst rlast", 64'(rlast), 64'd0);
        hi = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (rvalid) hi++;
        end
        check("rst no beats", 64'(hi), 64'd0);
        do_burst(vecs[0], "post rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
